// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen geometry, position types and mover state encoding
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] pos_x_t;
  typedef logic [8:0] pos_y_t;

  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_FROZEN   = 2'd1,
    ST_FINISHED = 2'd2
  } mover_state_t;

  // Move one axis by dir*step and pin the result inside 0..max_pos.
  function automatic int clamp_step(input int pos, input int dir, input int step,
                                    input int max_pos);
    int t;
    t = pos + dir * step;
    if (t < 0) return 0;
    if (t > max_pos) return max_pos;
    return t;
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// rtl/move_tick_gen.sv - free-running 0..TICK_DIV-1 counter producing the movement tick
module move_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/player_mover.sv
// rtl/player_mover.sv - tick-paced player position with edge saturation and play/frozen/finished FSM
// Define PLAYER_MOVER_DIAG_EN to let x and y both move on the same tick.
module player_mover
  import game_pkg::*;
#(
  parameter int START_X  = 320,
  parameter int START_Y  = 440,
  parameter int STEP     = 4,
  parameter int TICK_DIV = 833333,
  parameter int FINISH_Y = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       freeze,
  input  logic       restart,
  output logic [9:0] current_x,
  output logic [8:0] current_y,
  output logic       step_valid,
  output logic       at_finish
);

  localparam pos_x_t START_XV = pos_x_t'(START_X);
  localparam pos_y_t START_YV = pos_y_t'(START_Y);

  mover_state_t state_q, state_d;
  pos_x_t       x_q, x_d;
  pos_y_t       y_q, y_d;
  logic         sv_q, sv_d;
  logic         tick;
  int           dx, dy, nx, ny;

  move_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(restart),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    sv_d    = 1'b0;
    dx      = 0;
    dy      = 0;

    // Opposing buttons cancel on their axis.
    if (btn_right && !btn_left) dx = 1;
    else if (btn_left && !btn_right) dx = -1;
    if (btn_down && !btn_up) dy = 1;
    else if (btn_up && !btn_down) dy = -1;
`ifndef PLAYER_MOVER_DIAG_EN
    if (dy != 0) dx = 0;
`endif

    nx = clamp_step(int'(x_q), dx, STEP, SCREEN_W - 1);
    ny = clamp_step(int'(y_q), dy, STEP, SCREEN_H - 1);

    if (restart) begin
      state_d = ST_PLAY;
      x_d     = START_XV;
      y_d     = START_YV;
    end else if (state_q == ST_PLAY) begin
      if (freeze) begin
        state_d = ST_FROZEN;
      end else if (tick) begin
        x_d  = pos_x_t'(nx);
        y_d  = pos_y_t'(ny);
        sv_d = (x_d != x_q) || (y_d != y_q);
        if (ny <= FINISH_Y) state_d = ST_FINISHED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PLAY;
      x_q     <= START_XV;
      y_q     <= START_YV;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sv_q    <= sv_d;
    end
  end

  assign current_x  = x_q;
  assign current_y  = y_q;
  assign step_valid = sv_q;
  assign at_finish  = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_player_mover.sv
// tb/tb_player_mover.sv - randomized and directed bench for player_mover against an integer model
module tb_player_mover;

  localparam int TICK_DIV = 4;
  localparam int STEP     = 4;
  localparam int FIN_Y    = 20;
`ifdef PLAYER_MOVER_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic freeze = 1'b0, restart = 1'b0;
  logic [9:0] xa, xb;
  logic [8:0] ya, yb;
  logic sva, svb, afa, afb;

  always #5 clk = ~clk;

  player_mover #(.START_X(320), .START_Y(440), .STEP(STEP), .TICK_DIV(TICK_DIV),
                 .FINISH_Y(FIN_Y)) dut_a (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .freeze(freeze), .restart(restart),
    .current_x(xa), .current_y(ya), .step_valid(sva), .at_finish(afa));

  player_mover #(.START_X(10), .START_Y(24), .STEP(STEP), .TICK_DIV(TICK_DIV),
                 .FINISH_Y(FIN_Y)) dut_b (
    .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down), .freeze(freeze), .restart(restart),
    .current_x(xb), .current_y(yb), .step_valid(svb), .at_finish(afb));

  int checks = 0;
  int failures = 0;
  int sx[2] = '{320, 10};
  int sy[2] = '{440, 24};
  int mx[2], my[2], mmode[2], msv[2];
  int mcnt;
  int pulses_a = 0, pulses_b = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference model: mode 0=play 1=frozen 2=finished; mcnt = cycles since counter start.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt = 0;
      for (int i = 0; i < 2; i++) begin
        mx[i] = sx[i]; my[i] = sy[i]; mmode[i] = 0; msv[i] = 0;
      end
    end else begin
      bit tk;
      tk = (mcnt == TICK_DIV - 1);
      mcnt = (restart || tk) ? 0 : mcnt + 1;
      for (int i = 0; i < 2; i++) begin
        int hx, vy, nx, ny;
        msv[i] = 0;
        if (restart) begin
          mx[i] = sx[i]; my[i] = sy[i]; mmode[i] = 0;
        end else if (mmode[i] == 0 && freeze) begin
          mmode[i] = 1;
        end else if (mmode[i] == 0 && tk) begin
          hx = int'(btn_right) - int'(btn_left);
          vy = int'(btn_down) - int'(btn_up);
          if (!DIAG && vy != 0) hx = 0;
          nx = clampi(mx[i] + hx * STEP, 639);
          ny = clampi(my[i] + vy * STEP, 479);
          msv[i] = (nx != mx[i] || ny != my[i]) ? 1 : 0;
          mx[i] = nx; my[i] = ny;
          if (ny <= FIN_Y) mmode[i] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 || reset === 1'b0) begin
      chk("x_a", int'(xa), mx[0]);
      chk("y_a", int'(ya), my[0]);
      chk("step_valid_a", int'(sva), msv[0]);
      chk("at_finish_a", int'(afa), (mmode[0] == 2) ? 1 : 0);
      chk("x_b", int'(xb), mx[1]);
      chk("y_b", int'(yb), my[1]);
      chk("step_valid_b", int'(svb), msv[1]);
      chk("at_finish_b", int'(afb), (mmode[1] == 2) ? 1 : 0);
      if (sva) pulses_a++;
      if (svb) pulses_b++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
  endtask

  task automatic clear_btns();
    btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
  endtask

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    cyc(2);
    chk("reset_x", int'(xa), 320);
    chk("reset_y", int'(ya), 440);
    chk("reset_sv", int'(sva), 0);
    chk("reset_fin", int'(afa), 0);
    reset = 1'b1;

    pulses_a = 0;
    cyc(20);
    chk("idle_x", int'(xa), 320);
    chk("idle_y", int'(ya), 440);
    chk("idle_pulses", pulses_a, 0);

    restart_pulse();
    pulses_a = 0;
    btn_up = 1;
    cyc(4); chk("up1_y", int'(ya), 436);
    cyc(4); chk("up2_y", int'(ya), 432);
    cyc(4); chk("up3_y", int'(ya), 428);
    chk("up_x", int'(xa), 320);
    cyc(1); chk("up_pulses", pulses_a, 3);
    clear_btns();

    restart_pulse();
    pulses_b = 0;
    btn_left = 1;
    cyc(4); chk("sat1_x", int'(xb), 6);
    cyc(4); chk("sat2_x", int'(xb), 2);
    cyc(4); chk("sat3_x", int'(xb), 0);
    cyc(4); chk("sat4_x", int'(xb), 0);
    cyc(1); chk("sat_pulses", pulses_b, 3);
    clear_btns();

    restart_pulse();
    btn_up = 1; btn_right = 1;
    cyc(4);
    chk("diag_x", int'(xa), DIAG ? 324 : 320);
    chk("diag_y", int'(ya), 436);
    clear_btns();

    restart_pulse();
    btn_left = 1;
    cyc(3);
    freeze = 1;
    cyc(1);
    freeze = 0;
    chk("frz_x", int'(xa), 320);
    chk("frz_sv", int'(sva), 0);
    btn_up = 1;
    cyc(8);
    chk("frz_hold_x", int'(xa), 320);
    chk("frz_hold_y", int'(ya), 440);
    btn_up = 0;
    restart_pulse();
    chk("rst_play_x", int'(xa), 320);
    chk("rst_play_y", int'(ya), 440);
    cyc(4);
    chk("play_again_x", int'(xa), 316);
    clear_btns();

    restart_pulse();
    btn_up = 1;
    cyc(4);
    chk("fin_y", int'(yb), 20);
    chk("fin_flag", int'(afb), 1);
    cyc(8);
    chk("fin_hold_y", int'(yb), 20);
    cyc(2);
    reset = 1'b0;
    #1;
    chk("async_y", int'(yb), 24);
    chk("async_fin", int'(afb), 0);
    chk("async_xa", int'(xa), 320);
    clear_btns();
    cyc(1);
    reset = 1'b1;

    for (int n = 0; n < 600; n++) begin
      btn_left  = ($urandom_range(0, 2) == 0);
      btn_right = ($urandom_range(0, 2) == 0);
      btn_up    = ($urandom_range(0, 2) != 0);
      btn_down  = ($urandom_range(0, 3) == 0);
      freeze    = ($urandom_range(0, 40) == 0);
      restart   = ($urandom_range(0, 50) == 0);
      if ($urandom_range(0, 150) == 0) begin
        reset = 1'b0;
        #2 reset = 1'b1;
      end
      cyc(1);
    end
    clear_btns();
    freeze = 0;
    restart = 0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_mover.md
PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameter START_X, 320, x coordinate loaded on reset/restart.
REQ-002 Parameter START_Y, 440, y coordinate loaded on reset/restart.
REQ-003 Parameter STEP, 4, pixels moved per tick per axis (1..15).
REQ-004 Parameter TICK_DIV, 833333, clk cycles per movement tick (>=2).
REQ-005 Parameter FINISH_Y, 20, y at or above which (y <= FINISH_Y) the player has finished.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-008 btn_left, btn_right, btn_up, btn_down  input  1 each  debounced, synchronous, active-high move requests.
REQ-009 freeze  input  1  synchronous, high = player eliminated; stop movement.
REQ-010 restart  input  1  synchronous single-cycle pulse; new round.
REQ-011 current_x  output  10  registered player x, range 0..639.
REQ-012 current_y  output  9  registered player y, range 0..479.
REQ-013 step_valid  output  1  one-cycle pulse in the cycle after a position change.
REQ-014 at_finish  output  1  high while state is FINISHED.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is asserted when count == TICK_DIV-1.
REQ-016 States SHALL be PLAY, FROZEN, FINISHED.
REQ-017 In PLAY on a tick, buttons SHALL be sampled; new position visible on current_x/current_y one clk later.
REQ-018 Left+right together SHALL cancel x motion; up+down together SHALL cancel y motion.
REQ-019 Moves SHALL saturate: x to 0 and 639, y to 0 and 479; no wrap-around (e.g. x=2, left, STEP=4 -> x=0).
REQ-020 step_valid SHALL pulse only if current_x or current_y actually changed (clamped-at-edge move -> no pulse).
REQ-021 PLAY -> FROZEN when freeze=1, taking priority over a coincident tick (no move that cycle).
REQ-022 PLAY -> FINISHED when the updated y <= FINISH_Y; at_finish rises in the same cycle as the position update.
REQ-023 FROZEN and FINISHED SHALL hold position and ignore buttons and freeze; exit only via restart.
REQ-024 restart SHALL have highest priority: load START_X/START_Y, clear tick counter, enter PLAY, no step_valid pulse.

Reset
REQ-025 reset=0 SHALL immediately set current_x=START_X, current_y=START_Y, tick count 0, state PLAY, step_valid=0, at_finish=0, regardless of clk.
REQ-026 Reset asserted mid-tick SHALL discard the pending move; counting restarts from 0 after release.

Configuration
REQ-027 Macro PLAYER_MOVER_DIAG_EN defined: x and y SHALL both update on one tick (diagonal moves).
REQ-028 Macro undefined: any net vertical request SHALL suppress horizontal motion for that tick.

Structure
REQ-029 Package game_pkg SHALL hold SCREEN_W=640, SCREEN_H=480, typedefs pos_x_t (10 bit), pos_y_t (9 bit), and the mover_state_t enum.
REQ-030 Tick counter SHALL be a sub-module move_tick_gen (clk, reset, clear, tick).

Verification (TICK_DIV=4, STEP=4 for sim)
REQ-031 Reset, no buttons, 20 cycles -> x=320, y=440, step_valid never high.
REQ-032 btn_up held 3 ticks -> y 440->436->432->428, one step_valid pulse per tick, x unchanged.
REQ-033 Restart, then force x to 2 via repeated left from small START_X=10 -> 6, 2, 0, then next tick x stays 0 with no step_valid.
REQ-034 btn_up+btn_right together: with DIAG_EN -> (324,436); without -> (320,436).
REQ-035 freeze=1 coincident with tick while btn_left held -> x stays 320, state FROZEN, later buttons ignored; restart -> PLAY at (320,440).
REQ-036 START_Y=24, FINISH_Y=20, btn_up one tick -> y=20, at_finish=1; further ticks hold y=20; reset=0 mid-count -> y=24, at_finish=0 asynchronously.
